// File: rtl/sn_psg_pkg.sv
// sn_psg_pkg: shared constants and types for the SN76489-compatible PSG blocks
package sn_psg_pkg;

    localparam int PRESC_W = 4;
    localparam int RATE_W  = 7;

    localparam logic [1:0] NF_16    = 2'd0;
    localparam logic [1:0] NF_32    = 2'd1;
    localparam logic [1:0] NF_64    = 2'd2;
    localparam logic [1:0] NF_TONE3 = 2'd3;

    localparam logic [RATE_W-1:0] RATE_16 = 7'd16;
    localparam logic [RATE_W-1:0] RATE_32 = 7'd32;
    localparam logic [RATE_W-1:0] RATE_64 = 7'd64;

    localparam logic [14:0] DEF_LFSR_INIT = 15'h4000;
    localparam logic [14:0] DEF_TAP_MASK  = 15'h0003;

    typedef struct packed {
        logic       fb;
        logic [1:0] nf;
    } noise_ctrl_t;

    // NF_TONE3 never uses the rate counter, so any reload value works there
    function automatic logic [RATE_W-1:0] rate_reload(input logic [1:0] nf);
        return (nf == NF_32) ? RATE_32 : (nf == NF_64) ? RATE_64 : RATE_16;
    endfunction

endpackage

// File: rtl/sn_noise_lfsr.sv
// sn_noise_lfsr: noise shift register with white/periodic feedback and lockup recovery
module sn_noise_lfsr
    import sn_psg_pkg::*;
#(
    parameter int                 LFSR_W    = 15,
    parameter logic [LFSR_W-1:0]  LFSR_INIT = DEF_LFSR_INIT,
    parameter logic [LFSR_W-1:0]  TAP_MASK  = DEF_TAP_MASK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              white,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb = white ? ^(r_lfsr & TAP_MASK) : r_lfsr[0];
    assign lfsr = r_lfsr;

    // load wins over shift; an all-zero register is re-seeded instead of shifted
    always_ff @(posedge clk) begin
        if (rst || load)
            r_lfsr <= LFSR_INIT;
        else if (shift)
            r_lfsr <= (r_lfsr == '0) ? LFSR_INIT : {w_fb, r_lfsr[LFSR_W-1:1]};
    end

endmodule

// File: rtl/sn_noise_gen.sv
// sn_noise_gen: PSG noise channel -- control register, rate divider and LFSR driving snd_out
module sn_noise_gen
    import sn_psg_pkg::*;
#(
    parameter int                 LFSR_W    = 15,
    parameter logic [LFSR_W-1:0]  LFSR_INIT = DEF_LFSR_INIT,
    parameter logic [LFSR_W-1:0]  TAP_MASK  = DEF_TAP_MASK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wr_en,
    input  logic [2:0] wr_data,
    input  logic       tone3_tick,
    output logic       snd_out,
    output logic       shift_strb
);

    noise_ctrl_t          r_ctrl;
    logic [PRESC_W-1:0]   r_presc;
    logic [RATE_W-1:0]    r_cnt;
    logic                 r_phase;
    logic                 r_strb;
    noise_ctrl_t          w_wr_ctrl;
    logic                 w_tick16;
    logic                 w_rate_evt;
    logic                 w_shift;
    logic [LFSR_W-1:0]    w_lfsr;

    assign w_wr_ctrl  = noise_ctrl_t'(wr_data);
    assign w_tick16   = ce && (r_presc == '1);
    assign w_rate_evt = w_tick16 && (r_cnt == RATE_W'(1)) && !r_phase;
    assign w_shift    = (r_ctrl.nf == NF_TONE3) ? tone3_tick : w_rate_evt;
    assign snd_out    = w_lfsr[0];
    assign shift_strb = r_strb;

    // free-running divide-by-16 of the chip clock enable; writes leave it alone
    always_ff @(posedge clk) begin
        if (rst)
            r_presc <= '0;
        else if (ce)
            r_presc <= r_presc + 1'b1;
    end

    // half-period down-counter; each phase 0->1 transition is one shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= RATE_16;
            r_phase <= 1'b0;
        end else if (wr_en) begin
            r_cnt   <= rate_reload(w_wr_ctrl.nf);
            r_phase <= 1'b0;
        end else if (w_tick16) begin
            r_cnt   <= (r_cnt == RATE_W'(1)) ? rate_reload(r_ctrl.nf) : r_cnt - 1'b1;
            r_phase <= (r_cnt == RATE_W'(1)) ? ~r_phase : r_phase;
        end
    end

    // control register and shift strobe; a write suppresses any coincident shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
            r_strb <= 1'b0;
        end else begin
            r_ctrl <= wr_en ? w_wr_ctrl : r_ctrl;
            r_strb <= w_shift && !wr_en;
        end
    end

    sn_noise_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_INIT (LFSR_INIT),
        .TAP_MASK  (TAP_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (wr_en),
        .shift (w_shift && !wr_en),
        .white (r_ctrl.fb),
        .lfsr  (w_lfsr)
    );

endmodule

// File: tb/tb_sn_noise_gen.sv
// tb_sn_noise_gen: directed self-checking bench for the PSG noise generator
module tb_sn_noise_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        ce_on;
    logic        half;
    logic        r_tog = 1'b0;
    logic        wr_en;
    logic [2:0]  wr_data;
    logic        tone3_tick;
    logic        snd_out;
    logic        shift_strb;
    int          checks = 0;
    int          failures = 0;
    int          ce_cnt = 0;
    int          n;
    int          p;
    int          first_ret;
    logic [14:0] m;

    sn_noise_gen dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tone3_tick (tone3_tick),
        .snd_out    (snd_out),
        .shift_strb (shift_strb)
    );

    always #5 clk = ~clk;

    assign ce = half ? r_tog : ce_on;

    // 50% enable source and a count of applied enables, mirroring the prescaler phase
    always @(posedge clk) begin
        r_tog  <= rst ? 1'b0 : ~r_tog;
        ce_cnt <= rst ? 0 : ce_cnt + (ce ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic wait_strb(input int max, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!shift_strb && cnt < max);
        chk("strb_seen", {31'd0, shift_strb}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ce_on = 1'b1; half = 1'b0;
        wr_en = 1'b0; wr_data = 3'd0; tone3_tick = 1'b0;
        cyc(3);
        chk("rst_snd", {31'd0, snd_out}, 32'd0);
        chk("rst_strb", {31'd0, shift_strb}, 32'd0);
        chk("rst_lfsr", {17'd0, dut.w_lfsr}, 32'h4000);
        chk("rst_ctrl", {29'd0, dut.r_ctrl}, 32'd0);
        wr_en = 1'b1; wr_data = 3'b111;
        cyc(3);
        chk("rst_wr_ctrl", {29'd0, dut.r_ctrl}, 32'd0);
        chk("rst_wr_lfsr", {17'd0, dut.w_lfsr}, 32'h4000);
        wr_en = 1'b0; rst = 1'b0;
        cyc(37);

        wr(3'b000);
        p = ce_cnt % 16;
        wait_strb(600, n);
        chk("nf0_first", n, 256 - p);
        chk("nf0_lfsr1", {17'd0, dut.w_lfsr}, 32'h2000);
        chk("nf0_snd1", {31'd0, snd_out}, 32'd0);
        for (int k = 2; k <= 16; k++) begin
            wait_strb(600, n);
            chk("nf0_interval", n, 512);
            chk("nf0_snd", {31'd0, snd_out}, (k % 15 == 14) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("strb_single", {31'd0, shift_strb}, 32'd0);

        wr(3'b001);
        p = ce_cnt % 16;
        wait_strb(1100, n);
        chk("nf1_first", n, 512 - p);
        wait_strb(1100, n);
        chk("nf1_interval", n, 1024);

        wr(3'b010);
        p = ce_cnt % 16;
        wait_strb(2100, n);
        chk("nf2_first", n, 1024 - p);
        wait_strb(2100, n);
        chk("nf2_interval", n, 2048);

        half = 1'b1;
        wr(3'b001);
        wait_strb(2200, n);
        wait_strb(2200, n);
        chk("nf1_half_interval", n, 2048);
        wr(3'b010);
        wait_strb(4200, n);
        wait_strb(4200, n);
        chk("nf2_half_interval", n, 4096);
        half = 1'b0;

        wr(3'b010);
        cyc(1000);
        chk("mid_no_strb", {31'd0, shift_strb}, 32'd0);
        wr(3'b000);
        p = ce_cnt % 16;
        wait_strb(300, n);
        chk("mid_first", n, 256 - p);

        ce_on = 1'b0;
        wr(3'b111);
        chk("w_ctrl", {29'd0, dut.r_ctrl}, 32'd7);
        chk("w_lfsr0", {17'd0, dut.w_lfsr}, 32'h4000);
        chk("w_snd0", {31'd0, snd_out}, 32'd0);
        m = 15'h4000;
        first_ret = 0;
        tone3_tick = 1'b1;
        for (int i = 1; i <= 32767; i++) begin
            cyc();
            m = {m[0] ^ m[1], m[14:1]};
            if (i <= 20) begin
                chk("w_lfsr", {17'd0, dut.w_lfsr}, {17'd0, m});
                chk("w_snd", {31'd0, snd_out}, {31'd0, m[0]});
                chk("w_strb", {31'd0, shift_strb}, 32'd1);
            end
            if (i == 14)
                chk("w_lfsr14", {17'd0, dut.w_lfsr}, 32'h4001);
            if (dut.w_lfsr == 15'h4000 && first_ret == 0)
                first_ret = i;
        end
        chk("w_period", first_ret, 32767);

        cyc(5);
        wr_en = 1'b1; wr_data = 3'b111;
        cyc();
        wr_en = 1'b0;
        chk("coll_strb", {31'd0, shift_strb}, 32'd0);
        chk("coll_lfsr", {17'd0, dut.w_lfsr}, 32'h4000);
        cyc();
        chk("coll_next_strb", {31'd0, shift_strb}, 32'd1);
        chk("coll_next_lfsr", {17'd0, dut.w_lfsr}, 32'h2000);
        tone3_tick = 1'b0;
        cyc();
        chk("idle_strb", {31'd0, shift_strb}, 32'd0);
        chk("idle_lfsr", {17'd0, dut.w_lfsr}, 32'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
